// File: rtl/axi_store_master.sv
// Single-beat AXI write initiator for the CPU store path (AW/W/B channels only).
// One store in flight; completion and error status come back as a registered pulse.
module axi_store_master #(
  parameter int unsigned ID_WIDTH   = 13,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned AXI_ID     = 0,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [1:0]            st_size,
  output logic                  st_done,
  output logic                  st_err,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP, FAULT} state_t;

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [2:0]            awsize_q, awsize_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  st_done_q, st_done_d;
  logic                  st_err_q, st_err_d;
  logic [CNT_W-1:0]      tcnt_q, tcnt_d;

  logic       misaligned;
  logic [7:0] strb_base;
  logic       aw_done;
  logic       w_done;
  logic       timeout_hit;
  logic       unused_bid;

  // Response ID is not checked: only one transaction is ever outstanding.
  assign unused_bid = ^m_axi_bid;

  always_comb begin
    misaligned = 1'b0;
    strb_base  = 8'h00;
    case (st_size)
      2'd0: begin misaligned = 1'b0;            strb_base = 8'h01; end
      2'd1: begin misaligned = st_addr[0];      strb_base = 8'h03; end
      2'd2: begin misaligned = |st_addr[1:0];   strb_base = 8'h0F; end
      default: begin misaligned = |st_addr[2:0]; strb_base = 8'hFF; end
    endcase
  end

  // A channel counts as done once its valid has dropped or is handshaking now.
  assign aw_done     = !awvalid_q || m_axi_awready;
  assign w_done      = !wvalid_q || m_axi_wready;
  assign timeout_hit = (TIMEOUT != 0) && (tcnt_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    st_done_d = 1'b0;
    st_err_d  = 1'b0;
    tcnt_d    = tcnt_q;
    case (state_q)
      IDLE: begin
        if (st_valid) begin
          awaddr_d = st_addr;
          awsize_d = {1'b0, st_size};
          wdata_d  = st_data << {st_addr[2:0], 3'b000};
          wstrb_d  = STRB_WIDTH'(strb_base << st_addr[2:0]);
          if (misaligned) begin
            state_d = FAULT;
          end else begin
            state_d   = ADDR_DATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end
      end
      ADDR_DATA: begin
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d = RESP;
          tcnt_d  = '0;
        end
      end
      RESP: begin
        if (m_axi_bvalid) begin
          state_d   = IDLE;
          st_done_d = 1'b1;
          st_err_d  = (m_axi_bresp != 2'b00);
        end else if (timeout_hit) begin
          state_d   = IDLE;
          st_done_d = 1'b1;
          st_err_d  = 1'b1;
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end
      FAULT: begin
        state_d   = IDLE;
        st_done_d = 1'b1;
        st_err_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      st_done_q <= 1'b0;
      st_err_q  <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      st_done_q <= st_done_d;
      st_err_q  <= st_err_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign st_ready      = (state_q == IDLE);
  assign st_done       = st_done_q;
  assign st_err        = st_err_q;
  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = awsize_q;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wlast   = wvalid_q;
  assign m_axi_bready  = (state_q == RESP);

endmodule

// File: tb/tb_axi_store_master.sv
// Directed bench for axi_store_master: hand-computed expectations checked with
// immediate assertions one cycle step at a time (TIMEOUT shortened to 8).
module tb_axi_store_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic [1:0]  st_size;
  logic        st_done;
  logic        st_err;
  logic [12:0] m_axi_awid;
  logic [63:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [12:0] m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  axi_store_master #(
    .ID_WIDTH(13), .ADDR_WIDTH(64), .DATA_WIDTH(64), .STRB_WIDTH(8),
    .AXI_ID(0), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_size(st_size), .st_done(st_done), .st_err(st_err),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
    .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [63:0] addr, input logic [63:0] data, input logic [1:0] size);
    st_valid = 1'b1;
    st_addr  = addr;
    st_data  = data;
    st_size  = size;
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bid = '0;
    m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
    step(); step();

    // Reset state
    check("rst_st_ready", 64'(st_ready), 64'h1);
    check("rst_st_done", 64'(st_done), 64'h0);
    check("rst_st_err", 64'(st_err), 64'h0);
    check("rst_awvalid", 64'(m_axi_awvalid), 64'h0);
    check("rst_wvalid", 64'(m_axi_wvalid), 64'h0);
    check("rst_bready", 64'(m_axi_bready), 64'h0);
    check("rst_awaddr", m_axi_awaddr, 64'h0);
    check("rst_wdata", m_axi_wdata, 64'h0);
    check("rst_wstrb", 64'(m_axi_wstrb), 64'h0);
    check("rst_awsize", 64'(m_axi_awsize), 64'h0);
    reset = 1'b0;
    step();

    // Dword store, slave ready immediately; bvalid raised early must be ignored
    request(64'h1000, 64'h1122334455667788, 2'd3);
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    step();
    st_valid = 1'b0;
    check("t1_awvalid", 64'(m_axi_awvalid), 64'h1);
    check("t1_wvalid", 64'(m_axi_wvalid), 64'h1);
    check("t1_wlast", 64'(m_axi_wlast), 64'h1);
    check("t1_awaddr", m_axi_awaddr, 64'h1000);
    check("t1_awsize", 64'(m_axi_awsize), 64'h3);
    check("t1_wstrb", 64'(m_axi_wstrb), 64'hFF);
    check("t1_wdata", m_axi_wdata, 64'h1122334455667788);
    check("t1_awburst", 64'(m_axi_awburst), 64'h1);
    check("t1_awlen", 64'(m_axi_awlen), 64'h0);
    check("t1_awid", 64'(m_axi_awid), 64'h0);
    check("t1_st_ready", 64'(st_ready), 64'h0);
    check("t1_bready_ad", 64'(m_axi_bready), 64'h0);
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
    step();
    check("t1_bready", 64'(m_axi_bready), 64'h1);
    check("t1_awvalid_off", 64'(m_axi_awvalid), 64'h0);
    check("t1_wvalid_off", 64'(m_axi_wvalid), 64'h0);
    check("t1_done_early", 64'(st_done), 64'h0);
    step();
    m_axi_bvalid = 1'b0;
    check("t1_done", 64'(st_done), 64'h1);
    check("t1_err", 64'(st_err), 64'h0);
    check("t1_ready_back", 64'(st_ready), 64'h1);
    check("t1_bready_off", 64'(m_axi_bready), 64'h0);

    // Byte store accepted in the st_done cycle, completed with SLVERR
    request(64'h1005, 64'h00000000000000AB, 2'd0);
    step();
    st_valid = 1'b0;
    check("t2_awvalid", 64'(m_axi_awvalid), 64'h1);
    check("t2_done_pulse", 64'(st_done), 64'h0);
    check("t2_wstrb", 64'(m_axi_wstrb), 64'h20);
    check("t2_wdata", m_axi_wdata, 64'h0000AB0000000000);
    check("t2_awsize", 64'(m_axi_awsize), 64'h0);
    check("t2_awaddr", m_axi_awaddr, 64'h1005);
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10;
    step();
    step();
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    check("t2_done", 64'(st_done), 64'h1);
    check("t2_err", 64'(st_err), 64'h1);

    // Half store, awready delayed 3 cycles, wready immediate
    m_axi_awready = 1'b0; m_axi_wready = 1'b1;
    request(64'h2002, 64'h000000000000BEEF, 2'd1);
    step();
    st_valid = 1'b0;
    check("t3_c1_awvalid", 64'(m_axi_awvalid), 64'h1);
    check("t3_c1_wvalid", 64'(m_axi_wvalid), 64'h1);
    check("t3_wstrb", 64'(m_axi_wstrb), 64'h0C);
    check("t3_wdata", m_axi_wdata, 64'h00000000BEEF0000);
    step();
    check("t3_c2_wvalid", 64'(m_axi_wvalid), 64'h0);
    check("t3_c2_awvalid", 64'(m_axi_awvalid), 64'h1);
    check("t3_c2_bready", 64'(m_axi_bready), 64'h0);
    step();
    check("t3_c3_awvalid", 64'(m_axi_awvalid), 64'h1);
    check("t3_c3_awaddr", m_axi_awaddr, 64'h2002);
    step();
    check("t3_c4_awvalid", 64'(m_axi_awvalid), 64'h1);
    check("t3_c4_awaddr", m_axi_awaddr, 64'h2002);
    check("t3_c4_bready", 64'(m_axi_bready), 64'h0);
    m_axi_awready = 1'b1;
    step();
    check("t3_awvalid_off", 64'(m_axi_awvalid), 64'h0);
    check("t3_bready", 64'(m_axi_bready), 64'h1);
    m_axi_bvalid = 1'b1;
    step();
    m_axi_bvalid = 1'b0;
    check("t3_done", 64'(st_done), 64'h1);
    check("t3_err", 64'(st_err), 64'h0);

    // Misaligned word store: no bus activity, error two cycles after accept
    request(64'h3006, 64'h12345678, 2'd2);
    step();
    st_valid = 1'b0;
    check("t4_awvalid", 64'(m_axi_awvalid), 64'h0);
    check("t4_wvalid", 64'(m_axi_wvalid), 64'h0);
    check("t4_st_ready", 64'(st_ready), 64'h0);
    check("t4_done_early", 64'(st_done), 64'h0);
    step();
    check("t4_done", 64'(st_done), 64'h1);
    check("t4_err", 64'(st_err), 64'h1);
    check("t4_awvalid_after", 64'(m_axi_awvalid), 64'h0);
    check("t4_st_ready_back", 64'(st_ready), 64'h1);

    // Timeout: bvalid never comes, done+err 8 cycles after RESP entry
    request(64'h4000, 64'hCAFEF00DCAFEF00D, 2'd3);
    step();
    st_valid = 1'b0;
    step();
    check("t5_resp_entry", 64'(m_axi_bready), 64'h1);
    for (int i = 1; i < 8; i++) begin
      step();
      check($sformatf("t5_wait%0d_done", i), 64'(st_done), 64'h0);
      check($sformatf("t5_wait%0d_bready", i), 64'(m_axi_bready), 64'h1);
    end
    step();
    check("t5_done", 64'(st_done), 64'h1);
    check("t5_err", 64'(st_err), 64'h1);
    check("t5_bready_off", 64'(m_axi_bready), 64'h0);

    // Reset while awvalid is high
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    request(64'h5000, 64'h1, 2'd3);
    step();
    st_valid = 1'b0;
    check("t6_awvalid", 64'(m_axi_awvalid), 64'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_awvalid_rst", 64'(m_axi_awvalid), 64'h0);
    check("t6_wvalid_rst", 64'(m_axi_wvalid), 64'h0);
    check("t6_bready_rst", 64'(m_axi_bready), 64'h0);
    check("t6_ready_rst", 64'(st_ready), 64'h1);
    check("t6_done_rst", 64'(st_done), 64'h0);
    step();
    check("t6_done_after", 64'(st_done), 64'h0);
    check("t6_awvalid_after", 64'(m_axi_awvalid), 64'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
